// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset PC and fetch FSM state encoding
package inst_fetch_pkg;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int IW = 32;
  localparam logic [AW-1:0] RESET_PC = '0;
  typedef enum logic [1:0] {FETCH, DRAIN, VALID} state_e;
endpackage

// File: rtl/inst_fetch_byte_asm.sv
// fetch_byte_asm: assembles four little-endian bytes into one instruction word
//   en_i  clock enable       clr_i clear word (wins over we_i)
//   we_i  write byte idx_i   din_i byte data        word_o assembled word
module fetch_byte_asm
  import inst_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [1:0]    idx_i,
  input  logic [DW-1:0] din_i,
  output logic [IW-1:0] word_o
);
  logic [IW-1:0] word_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else if (en_i) begin
      if (clr_i) word_q <= '0;
      else if (we_i) word_q[{idx_i, 3'b000} +: DW] <= din_i;
    end
  end
  assign word_o = word_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch with redirect, stall and rdy freeze
//   if_mem_req_o/if_mem_addr_o/if_grant_i/mem_din_i  byte memory port
//   branch_flag_i/branch_target_i  redirect   stall_i  downstream hold
//   inst_valid_o/inst_o/pc_o  fetched instruction and its address
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  output logic          if_mem_req_o,
  output logic [AW-1:0] if_mem_addr_o,
  input  logic          if_grant_i,
  input  logic [DW-1:0] mem_din_i,
  input  logic          branch_flag_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          stall_i,
  output logic          inst_valid_o,
  output logic [IW-1:0] inst_o,
  output logic [AW-1:0] pc_o
);
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    cnt_q, cnt_d, idx_q, idx_d;
  logic          fly_q, fly_d, run_q;
  // run_q keeps the request low until the first enabled edge after reset
  assign if_mem_req_o  = run_q && state_q == FETCH;
  assign if_mem_addr_o = pc_q + AW'(cnt_q);
  assign inst_valid_o  = state_q == VALID;
  assign pc_o          = pc_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fly_d   = 1'b0;
    if (branch_flag_i) begin
      state_d = FETCH;
      pc_d    = branch_target_i;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FETCH: if (if_mem_req_o && if_grant_i) begin
          fly_d   = 1'b1;
          idx_d   = cnt_q;
          cnt_d   = cnt_q + 2'd1;
          state_d = cnt_q == 2'd3 ? DRAIN : FETCH;
        end
        DRAIN: state_d = fly_q && idx_q == 2'd3 ? VALID : DRAIN;
        VALID: if (!stall_i) begin
          pc_d    = pc_q + AW'(4);
          cnt_d   = '0;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      idx_q   <= '0;
      fly_q   <= 1'b0;
      run_q   <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fly_q   <= fly_d;
      run_q   <= 1'b1;
    end
  end
  // a redirect clears the word and drops any byte returning in that cycle
  fetch_byte_asm u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (rdy),
    .clr_i  (branch_flag_i),
    .we_i   (fly_q),
    .idx_i  (idx_q),
    .din_i  (mem_din_i),
    .word_o (inst_o)
  );
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rdy, input, 1; low freezes all state and outputs.
REQ-004 SHALL have port if_mem_req_o, output, 1; fetch byte request to memory arbiter.
REQ-005 SHALL have port if_mem_addr_o, output, 32; byte address of requested byte.
REQ-006 SHALL have port if_grant_i, input, 1; arbiter placed if_mem_addr_o on the memory bus this cycle.
REQ-007 SHALL have port mem_din_i, input, 8; read byte, valid the cycle after its granted address.
REQ-008 SHALL have port branch_flag_i, input, 1; redirect request.
REQ-009 SHALL have port branch_target_i, input, 32; redirect PC.
REQ-010 SHALL have port stall_i, input, 1; downstream hold.
REQ-011 SHALL have port inst_valid_o, output, 1; inst_o and pc_o valid.
REQ-012 SHALL have port inst_o, output, 32; assembled instruction.
REQ-013 SHALL have port pc_o, output, 32; address of inst_o.

Function
REQ-014 SHALL keep state FETCH (issuing bytes), DRAIN (last byte in flight), VALID (presenting instruction).
REQ-015 SHALL in FETCH drive if_mem_req_o=1, if_mem_addr_o=pc+issue_cnt (issue_cnt 0..3).
REQ-016 SHALL advance issue_cnt only in cycles with if_grant_i=1; no grant -> same address held, no byte lost.
REQ-017 SHALL capture mem_din_i one cycle after each grant into inst bits [8k+7:8k], k = byte index (little-endian).
REQ-018 SHALL go FETCH->DRAIN on grant of byte 3, deasserting if_mem_req_o in DRAIN.
REQ-019 SHALL go DRAIN->VALID on capture of byte 3; inst_valid_o=1 in VALID.
REQ-020 SHALL with continuous grant, first request in cycle C, assert inst_valid_o in cycle C+5.
REQ-021 SHALL treat instruction consumed in any VALID cycle with stall_i=0; then pc<=pc+4, issue_cnt<=0, FETCH next cycle.
REQ-022 SHALL hold inst_o, pc_o, inst_valid_o stable while stall_i=1.
REQ-023 SHALL keep if_mem_req_o=0 in VALID (no prefetch).
REQ-024 SHALL on branch_flag_i=1 in any state: pc<=branch_target_i, issue_cnt<=0, discard partial word, inst_valid_o=0 next cycle, enter FETCH.
REQ-025 SHALL discard a byte returning the cycle after a redirect (in-flight byte of old stream).
REQ-026 SHALL give branch_flag_i priority over consumption and over byte-3 capture in the same cycle.
REQ-027 SHALL wrap pc and byte address modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-028 SHALL with rdy=0 neither advance counters, change state, nor capture data; rdy SHALL gate the clock enable of every register.

Reset
REQ-029 SHALL on rst_n=0 immediately set pc=0x00000000, issue_cnt=0, state FETCH, inst_o=0, pc_o=0, inst_valid_o=0, if_mem_req_o=0, if_mem_addr_o=0.
REQ-030 SHALL resume on first rising edge after rst_n release by requesting address 0x00000000; reset mid-fetch SHALL discard all partial bytes and pending in-flight flags.

Structure
REQ-031 SHALL place state encoding, RESET_PC (0x00000000), address width 32, memory data width 8 and instruction width 32 in the shared defines package.
REQ-032 SHALL factor byte capture and word assembly into one sub-module, fetch_byte_asm (byte index, data, write enable, clear in; 32-bit word out).

Verification
REQ-033 SHALL cover: reset, grant always 1, memory bytes 13 00 00 00 at 0..3 -> reqs to 0,1,2,3 in C..C+3; C+5 inst_o=0x00000013, pc_o=0, inst_valid_o=1.
REQ-034 SHALL cover: if_grant_i=0 for 3 cycles while requesting byte 2 -> address held at pc+2, inst_valid_o delayed exactly 3 cycles, word correct.
REQ-035 SHALL cover: stall_i=1 for 4 cycles in VALID -> outputs unchanged 4 cycles; stall_i=0 -> next request at pc+4.
REQ-036 SHALL cover: branch_flag_i=1, target 0x00000100, after byte 1 granted -> returning byte discarded, next request 0x100, pc_o=0x100 on next valid.
REQ-037 SHALL cover: branch coincident with byte-3 capture -> no valid pulse, fetch restarts at target.
REQ-038 SHALL cover: rst_n low in DRAIN, pc=0xFFFFFFFC -> all outputs zero immediately; after release, first request 0x00000000; separately pc=0xFFFFFFFC consumed -> next request 0x00000000.
